spr_in_pack: RTL

Input packer and line re-timer in front of the SPR pipeline (`spr_top`). It takes a 1-pixel-per-clock 30-bit RGB stream and groups pixels into 4-pixel 120-bit words in a ping-pong line buffer. It then replays each completed line as one contiguous `o_de` burst, framed by `o_hs`/`o_vs`, with the pre-roll, tail and gap spacing the SPR pipeline needs to flush and toggle its odd/even phase.

---
 rtl/spr_in_pack.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/spr_in_pack.sv
// Packs a 1-pixel/clk RGB stream into 4-pixel words in a ping-pong line buffer and replays each line as one burst.
// Optional SPR_PACK_EDGE_REPEAT_EN: a partial final group repeats its last pixel instead of padding with zero.
module spr_in_pack #(
    parameter int MAX_WORDS = 480,
    parameter int AW        = 9,
    parameter int TAIL      = 24,
    parameter int GAP       = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_vs,
    input  logic         i_hs,
    input  logic         i_de,
    input  logic [29:0]  i_data,
    output logic         o_vs,
    output logic         o_hs,
    output logic         o_de,
    output logic [119:0] o_data,
    output logic         o_ovf
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PRE  = 3'd1;
    localparam logic [2:0] S_ACT  = 3'd2;
    localparam logic [2:0] S_TAIL = 3'd3;
    localparam logic [2:0] S_GAP  = 3'd4;

    logic [119:0] mem [0:(2**(AW+1))-1];

    logic [2:0]   state;
    logic [15:0]  tmr;
    logic [AW:0]  raddr;
    logic [AW:0]  waddr;
    logic [AW:0]  cnt [0:1];
    logic [1:0]   full;
    logic         wb, rb;
    logic         de_d, vs_d;
    logic         drop, excess;
    logic [1:0]   gcnt;
    logic [29:0]  gather [0:3];

    logic         sol, eol, vs_rise, vs_clear, release_bank, room;
    logic         line_drop, accept, wr_en;
    logic [29:0]  pad;
    logic [119:0] wr_data;

    // Line framing comes from i_de alone, so i_hs is intentionally not consumed.
    logic unused_hs;
    assign unused_hs = i_hs;

    assign sol          = i_de & ~de_d;
    assign eol          = de_d & ~i_de;
    assign vs_rise      = i_vs & ~vs_d;
    assign vs_clear     = vs_rise && (state == S_IDLE) && (full == 2'b00);
    assign release_bank = (state == S_TAIL) && (tmr == 16'(TAIL - 1));
    assign room         = waddr < (AW+1)'(MAX_WORDS);
    assign o_vs         = vs_d | (state != S_IDLE) | full[0] | full[1];

    always_comb begin
        line_drop = sol ? full[wb] : drop;
        accept    = i_de && !line_drop && room;
`ifdef SPR_PACK_EDGE_REPEAT_EN
        pad = gather[gcnt - 2'd1];
`else
        pad = '0;
`endif
        case (gcnt)
            2'd1:    wr_data = {pad, pad, pad, gather[0]};
            2'd2:    wr_data = {pad, pad, gather[1], gather[0]};
            default: wr_data = {pad, gather[2], gather[1], gather[0]};
        endcase
        wr_en = 1'b0;
        if (accept && gcnt == 2'd3) begin
            wr_en   = 1'b1;
            wr_data = {i_data, gather[2], gather[1], gather[0]};
        end else if (eol && !drop && gcnt != 2'd0) begin
            wr_en = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[{wb, waddr[AW-1:0]}] <= wr_data;
    end

    // Bank release is applied before a line finish, so a finish on the same cycle still marks its bank full.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_ovf  <= 1'b0;
            vs_d   <= 1'b0;
            de_d   <= 1'b0;
            wb     <= 1'b0;
            rb     <= 1'b0;
            full   <= 2'b00;
            waddr  <= '0;
            cnt[0] <= '0;
            cnt[1] <= '0;
            gcnt   <= 2'd0;
            drop   <= 1'b0;
            excess <= 1'b0;
            for (int i = 0; i < 4; i++) gather[i] <= '0;
        end else begin
            o_ovf <= 1'b0;
            vs_d  <= i_vs;
            de_d  <= i_de;
            if (release_bank) begin
                full[rb] <= 1'b0;
                rb       <= ~rb;
            end
            if (vs_clear) begin
                wb     <= 1'b0;
                rb     <= 1'b0;
                full   <= 2'b00;
                waddr  <= '0;
                gcnt   <= 2'd0;
                drop   <= 1'b0;
                excess <= 1'b0;
                for (int i = 0; i < 4; i++) gather[i] <= '0;
            end else begin
                if (vs_rise) o_ovf <= 1'b1;
                if (sol) begin
                    drop   <= full[wb];
                    excess <= 1'b0;
                    if (full[wb]) o_ovf <= 1'b1;
                end
                if (accept) begin
                    gather[gcnt] <= i_data;
                    gcnt         <= gcnt + 2'd1;
                    if (gcnt == 2'd3) waddr <= waddr + 1'b1;
                end
                if (i_de && !line_drop && !room && !excess) begin
                    excess <= 1'b1;
                    o_ovf  <= 1'b1;
                end
                if (eol) begin
                    drop <= 1'b0;
                    if (!drop) begin
                        cnt[wb]  <= waddr + (AW+1)'(gcnt != 2'd0);
                        full[wb] <= 1'b1;
                        wb       <= ~wb;
                        waddr    <= '0;
                        gcnt     <= 2'd0;
                    end
                end
            end
        end
    end

    // raddr runs one cycle ahead of o_de so the registered memory read lines up with the strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            tmr    <= '0;
            raddr  <= '0;
            o_hs   <= 1'b0;
            o_de   <= 1'b0;
            o_data <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (full[rb]) begin
                        state <= S_PRE;
                        o_hs  <= 1'b1;
                        raddr <= '0;
                        tmr   <= '0;
                    end
                end
                S_PRE: begin
                    if (tmr == 16'd1) begin
                        state  <= S_ACT;
                        o_de   <= 1'b1;
                        o_data <= mem[{rb, raddr[AW-1:0]}];
                        raddr  <= raddr + 1'b1;
                        tmr    <= '0;
                    end else begin
                        tmr <= tmr + 16'd1;
                    end
                end
                S_ACT: begin
                    if (raddr == cnt[rb]) begin
                        state <= S_TAIL;
                        o_de  <= 1'b0;
                        tmr   <= '0;
                    end else begin
                        o_data <= mem[{rb, raddr[AW-1:0]}];
                        raddr  <= raddr + 1'b1;
                    end
                end
                S_TAIL: begin
                    if (tmr == 16'(TAIL - 1)) begin
                        state <= S_GAP;
                        o_hs  <= 1'b0;
                        tmr   <= '0;
                    end else begin
                        tmr <= tmr + 16'd1;
                    end
                end
                S_GAP: begin
                    if (tmr == 16'(GAP - 1)) begin
                        state <= S_IDLE;
                        tmr   <= '0;
                    end else begin
                        tmr <= tmr + 16'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
